mips_multi_core: RTL and testbench
==================================

# mips_multi_core

Parametrised multicycle MIPS core, next generation of the board-level multicycle CPU. It fetches from a synchronous instruction ROM, runs a HALT/FETCH/DECODE/EXEC/MEM/WB state machine, and talks to the data cache through a request/stall handshake. It owns its register file and exposes a board debug read port and a retired-instruction counter.

## Interface
- `DATA_W`, 32: datapath and register width (≥16); immediates sign-extend to DATA_W.
- `PC_W`, 10: word-addressed PC width.
- `ADDR_W`, 12: data-memory word address width.
- `CNT_W`, 16: retired-instruction counter width.
- `clk`  in  1: single clock, all state on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `run`  in  1: leave HALT when 1.
- `inst_addr`  out  PC_W: equals PC (combinational).
- `inst_data`  in  32: ROM output, valid one cycle after `inst_addr` is stable.
- `mem_addr`  out  ADDR_W: ALUOut[ADDR_W-1:0] during MEM_REQ/MEM_WAIT, else 0.
- `mem_wdata`  out  DATA_W: B during store MEM states, else 0.
- `mem_rd` / `mem_wr`  out  1: load/store request, high through MEM_REQ and MEM_WAIT.
- `mem_stall`  in  1: cache busy; held high until data ready or write done.
- `mem_rdata`  in  DATA_W: load data, valid on the cycle `mem_stall` is low in MEM_WAIT.
- `dbg_sel`  in  5: register index for board display.
- `dbg_reg`  out  DATA_W: register file[dbg_sel], combinational; 0 for index 0.
- `illegal`  out  1: sticky, set on undecodable instruction.
- `retired`  out  CNT_W: instructions completed, wraps modulo 2^CNT_W.
- `state`  out  3: current FSM state encoding, for LEDs.

## Operation
- Reset (async): state=HALT, PC=0, IR/A/B/ALUOut/MDR=0, `illegal`=0, `retired`=0, register file cleared; all request outputs 0.
- HALT: stay while `run`=0; on `run`=1 -> FETCH. HALT always lasts ≥1 cycle so the ROM registers PC.
- FETCH: IR<=inst_data, PC<=PC+1 (wraps at 2^PC_W) -> DECODE.
- DECODE: A<=R[rs], B<=R[rt], imm<=sext(IR[15:0]) -> EXEC. Unknown opcode/funct: set `illegal`, go to WB as a no-op (counted as retired).
- EXEC: add/sub/and/or/slt (funct 20/22/24/25/2A hex), addi (08): ALUOut computed -> WB. slt is signed, result 1 or 0. beq (04)/bne (05): if taken, PC<=PC+imm[PC_W-1:0] (PC already +1) -> WB. j (02): PC<=IR[PC_W-1:0] -> WB. lw (23)/sw (2B): ALUOut<=A+imm -> MEM_REQ.
- MEM_REQ: one cycle, request asserted -> MEM_WAIT.
- MEM_WAIT: request held; stay while `mem_stall`=1; on `mem_stall`=0, load captures MDR<=mem_rdata -> WB.
- WB: R-type writes rd, addi writes rt from ALUOut, lw writes rt from MDR; writes to R0 are discarded. `retired`+=1. If `run`=0 -> HALT, else -> FETCH.
- Arithmetic wraps at DATA_W; no overflow traps.

## Timing
- Cycles per instruction: R/addi/branch/j/illegal 4 (FETCH..WB), lw/sw 6 + stall cycles.
- `mem_stall` is sampled only in MEM_WAIT; stall high in MEM_REQ is ignored. Stall asserted outside MEM states is ignored.
- Register write takes effect at WB edge; the next DECODE reads the new value (no bypass needed).
- `rst_n` low in any state, including mid-MEM_WAIT: requests drop asynchronously, no write completes from the core side.
- `run` deasserted mid-instruction: instruction finishes, core halts after WB.

## Structure
- Package `mips_pkg`: state encodings, opcode/funct constants, ALU op enum.
- Sub-module `mips_regfile`: 32×DATA_W, two async read ports + debug read port, one sync write port, async clear, R0 hardwired 0.

## Test plan
- Reset then `run`=1, program `addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2` -> R3=2, `retired`=3 after 12 cycles from first FETCH.
- `sw $1,4($0)` with `mem_stall` high 3 cycles -> `mem_wr`=1, `mem_addr`=4, `mem_wdata`=5 for 5 cycles, then WB.
- `lw $4,4($0)`, cache returns 0x1234 with 0 stall -> R4=0x1234, instruction takes 6 cycles.
- `beq` taken with imm=-1 at PC 7 -> next fetch at PC 7 (loop); `bne` same operands -> PC 8.
- `slt` with A=-1, B=1 -> 1; `add $0,$1,$1` -> R0 stays 0; opcode 0x3F -> `illegal`=1, regs unchanged.
- `rst_n` pulsed low during MEM_WAIT -> `mem_rd`=0 immediately, state=HALT, PC=0, `retired`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the multicycle MIPS core: FSM states,
// opcode/funct constants, ALU ops and the instruction classifier.
package mips_pkg;

  typedef enum logic [2:0] {
    S_HALT     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_MEM_REQ  = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_WB       = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  typedef enum logic [2:0] {
    C_ILL,
    C_RTYPE,
    C_ADDI,
    C_BEQ,
    C_BNE,
    C_J,
    C_LW,
    C_SW
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  function automatic iclass_t classify(
    input logic [31:0] ir
  );
    logic [5:0] op;
    logic [5:0] fn;
    logic       fn_ok;
    iclass_t    c;
    op    = ir[31:26];
    fn    = ir[5:0];
    fn_ok = fn inside {FN_ADD, FN_SUB, FN_AND,
                       FN_OR, FN_SLT};
    c     = C_ILL;
    unique case (1'b1)
      op == OP_RTYPE: c = fn_ok ? C_RTYPE : C_ILL;
      op == OP_ADDI:  c = C_ADDI;
      op == OP_BEQ:   c = C_BEQ;
      op == OP_BNE:   c = C_BNE;
      op == OP_J:     c = C_J;
      op == OP_LW:    c = C_LW;
      op == OP_SW:    c = C_SW;
      default:        c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic alu_op_t alu_sel(
    input logic [5:0] fn
  );
    alu_op_t o;
    o = ALU_ADD;
    unique case (1'b1)
      fn == FN_SUB: o = ALU_SUB;
      fn == FN_AND: o = ALU_AND;
      fn == FN_OR:  o = ALU_OR;
      fn == FN_SLT: o = ALU_SLT;
      default:      o = ALU_ADD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32-entry register file: two async read ports, a debug read
// port, one sync write port, async clear; R0 is never written.
module mips_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  input  logic [4:0]        ra3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
  assign rd3 = regs[ra3];

endmodule

// File: rtl/mips_multi_core.sv
// Multicycle MIPS core: HALT/FETCH/DECODE/EXEC/MEM/WB FSM,
// sync ROM fetch, stall-handshake data port, debug reg read.
module mips_multi_core
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 10,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [PC_W-1:0]   inst_addr,
  input  logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_stall,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [4:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_reg,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired,
  output logic [2:0]        state
);

  state_t            st;
  logic [PC_W-1:0]   pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, imm;
  logic [DATA_W-1:0] alu_out, mdr;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic [DATA_W-1:0] opb, alu_res;
  iclass_t           cls;
  alu_op_t           op;
  logic              in_mem;
  logic              rf_we;
  logic [4:0]        rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic [PC_W-1:0]   pc_br;

  // IR only changes in FETCH, so the class holds until WB
  assign cls = classify(ir);
  assign op  = (cls == C_RTYPE) ? alu_sel(ir[5:0])
                                : ALU_ADD;
  assign opb = (cls == C_RTYPE) ? b : imm;

  always_comb begin
    alu_res = '0;
    unique case (op)
      ALU_ADD: alu_res = a + opb;
      ALU_SUB: alu_res = a - opb;
      ALU_AND: alu_res = a & opb;
      ALU_OR:  alu_res = a | opb;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}},
                          $signed(a) < $signed(opb)};
      default: alu_res = '0;
    endcase
  end

  assign pc_br     = pc + imm[PC_W-1:0];
  assign inst_addr = pc;
  assign state     = st;

  assign in_mem    = (st == S_MEM_REQ) || (st == S_MEM_WAIT);
  assign mem_rd    = in_mem && (cls == C_LW);
  assign mem_wr    = in_mem && (cls == C_SW);
  assign mem_addr  = in_mem ? alu_out[ADDR_W-1:0] : '0;
  assign mem_wdata = mem_wr ? b : '0;

  assign rf_we = (st == S_WB) &&
                 (cls inside {C_RTYPE, C_ADDI, C_LW});
  assign rf_wa = (cls == C_RTYPE) ? ir[15:11] : ir[20:16];
  assign rf_wd = (cls == C_LW) ? mdr : alu_out;

  mips_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ir[25:21]),
    .ra2   (ir[20:16]),
    .ra3   (dbg_sel),
    .rd1   (rs_data),
    .rd2   (rt_data),
    .rd3   (dbg_reg),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (rf_wd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_HALT;
      pc      <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      unique case (st)
        S_HALT: if (run) st <= S_FETCH;
        S_FETCH: begin
          ir <= inst_data;
          pc <= pc + 1'b1;
          st <= S_DECODE;
        end
        S_DECODE: begin
          a   <= rs_data;
          b   <= rt_data;
          imm <= DATA_W'($signed(ir[15:0]));
          if (cls == C_ILL) illegal <= 1'b1;
          st  <= S_EXEC;
        end
        S_EXEC: begin
          st <= S_WB;
          unique case (1'b1)
            cls inside {C_RTYPE, C_ADDI}:
              alu_out <= alu_res;
            cls == C_BEQ: if (a == b) pc <= pc_br;
            cls == C_BNE: if (a != b) pc <= pc_br;
            cls == C_J:   pc <= ir[PC_W-1:0];
            cls inside {C_LW, C_SW}: begin
              alu_out <= alu_res;
              st      <= S_MEM_REQ;
            end
            default: ;
          endcase
        end
        S_MEM_REQ: st <= S_MEM_WAIT;
        S_MEM_WAIT: if (!mem_stall) begin
          if (cls == C_LW) mdr <= mem_rdata;
          st <= S_WB;
        end
        S_WB: begin
          retired <= retired + 1'b1;
          st      <= run ? S_FETCH : S_HALT;
        end
        default: st <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multi_core.sv
// Bench for mips_multi_core: ISA-level reference model, per-cycle
// compare process, directed program and literal spot checks.
module tb_mips_multi_core;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, run;
  logic [9:0]  inst_addr;
  logic [31:0] inst_data;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd, mem_wr, mem_stall;
  logic [31:0] mem_rdata;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_reg;
  logic        illegal;
  logic [15:0] retired;
  logic [2:0]  state;

  mips_multi_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_stall (mem_stall),
    .mem_rdata (mem_rdata),
    .dbg_sel   (dbg_sel),
    .dbg_reg   (dbg_reg),
    .illegal   (illegal),
    .retired   (retired),
    .state     (state)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [1024];
  always @(posedge clk) inst_data <= rom[inst_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model state
  logic [31:0] mregs [32];
  logic [9:0]  mpc, nxt;
  int          mret, memop, total, wcnt;
  logic        mill;
  int          stalls [2] = '{3, 0};
  logic [31:0] rdv    [2] = '{32'h0, 32'h1234};

  // per-instruction prediction
  logic [31:0] w, simm, av, bv, wv, addr, wdat;
  logic [4:0]  wa;
  logic        wr, ill, ismem, islw, issw, inwin;
  int          lat, s;
  logic [4:0]  sel;
  logic        found;

  function automatic state_t phase(input int k, input int l,
                                   input logic m);
    if (k == 0) return S_FETCH;
    if (k == 1) return S_DECODE;
    if (k == 2) return S_EXEC;
    if (k == l - 1) return S_WB;
    if (m && k == 3) return S_MEM_REQ;
    return S_MEM_WAIT;
  endfunction

  task automatic predict();
    logic [5:0] op;
    logic [5:0] fn;
    w     = rom[mpc];
    op    = w[31:26];
    fn    = w[5:0];
    simm  = {{16{w[15]}}, w[15:0]};
    av    = mregs[w[25:21]];
    bv    = mregs[w[20:16]];
    lat   = 4;
    nxt   = mpc + 10'd1;
    wr    = 1'b0; wa = 5'd0; wv = 32'h0; ill = 1'b0;
    ismem = 1'b0; islw = 1'b0; issw = 1'b0; s = 0;
    addr  = 32'h0; wdat = 32'h0;
    case (op)
      6'h00: begin
        wr = 1'b1; wa = w[15:11];
        case (fn)
          6'h20: wv = av + bv;
          6'h22: wv = av - bv;
          6'h24: wv = av & bv;
          6'h25: wv = av | bv;
          6'h2A: wv = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
          default: begin wr = 1'b0; ill = 1'b1; end
        endcase
      end
      6'h08: begin wr = 1'b1; wa = w[20:16]; wv = av + simm; end
      6'h04: if (av == bv) nxt = mpc + 10'd1 + simm[9:0];
      6'h05: if (av != bv) nxt = mpc + 10'd1 + simm[9:0];
      6'h02: nxt = w[9:0];
      6'h23, 6'h2B: begin
        ismem = 1'b1;
        s     = stalls[memop];
        lat   = 6 + s;
        addr  = av + simm;
        if (op == 6'h23) begin
          islw = 1'b1; wr = 1'b1; wa = w[20:16]; wv = rdv[memop];
        end else begin
          issw = 1'b1; wdat = bv;
        end
      end
      default: ill = 1'b1;
    endcase
  endtask

  task automatic lit(input int n);
    case (n)
      3: begin
        chk("lit_retired3", {16'h0, retired}, 32'd3);
        chk("lit_cycles12", total, 32'd12);
        dbg_sel = 5'd3; #1;
        chk("lit_r3", dbg_reg, 32'd2);
      end
      4: chk("lit_sw_window", wcnt, 32'd5);
      5: begin
        chk("lit_cycles27", total, 32'd27);
        dbg_sel = 5'd4; #1;
        chk("lit_r4", dbg_reg, 32'h1234);
      end
      8: begin dbg_sel = 5'd5; #1; chk("lit_slt", dbg_reg, 32'd1); end
      9: begin dbg_sel = 5'd0; #1; chk("lit_r0", dbg_reg, 32'd0); end
      10: chk("lit_illegal", {31'h0, illegal}, 32'd1);
      11: chk("lit_bne_pc", {22'h0, inst_addr}, 32'd11);
      17: begin
        chk("lit_beq_pc", {22'h0, inst_addr}, 32'd16);
        dbg_sel = 5'd11; #1;
        chk("lit_j_skip", dbg_reg, 32'd0);
      end
      default: ;
    endcase
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
    rom[0]  = 32'h20010005; // addi $1,$0,5
    rom[1]  = 32'h2002FFFD; // addi $2,$0,-3
    rom[2]  = 32'h00221820; // add  $3,$1,$2
    rom[3]  = 32'hAC010004; // sw   $1,4($0)
    rom[4]  = 32'h8C040004; // lw   $4,4($0)
    rom[5]  = 32'h2006FFFF; // addi $6,$0,-1
    rom[6]  = 32'h20070001; // addi $7,$0,1
    rom[7]  = 32'h00C7282A; // slt  $5,$6,$7
    rom[8]  = 32'h00210020; // add  $0,$1,$1
    rom[9]  = 32'hFC000000; // opcode 3F
    rom[10] = 32'h14210005; // bne  $1,$1,5
    rom[11] = 32'h00224022; // sub  $8,$1,$2
    rom[12] = 32'h00224824; // and  $9,$1,$2
    rom[13] = 32'h00225025; // or   $10,$1,$2
    rom[14] = 32'h08000010; // j    16
    rom[15] = 32'h200B0063; // addi $11,$0,99
    rom[16] = 32'h1021FFFF; // beq  $1,$1,-1

    rst_n = 1'b0; run = 1'b0; mem_stall = 1'b0;
    mem_rdata = 32'h0; dbg_sel = 5'd0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mpc = 10'd0; mret = 0; mill = 1'b0; memop = 0;
    total = 0; wcnt = 0; sel = 5'd0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", {29'h0, state}, {29'h0, S_HALT});
    chk("rst_pc", {22'h0, inst_addr}, 32'd0);
    chk("rst_retired", {16'h0, retired}, 32'd0);
    chk("rst_illegal", {31'h0, illegal}, 32'd0);
    chk("rst_req", {30'h0, mem_rd, mem_wr}, 32'd0);
    chk("rst_maddr", {20'h0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);

    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) run = 1'b1;

    for (int n = 0; n < 19; n++) begin
      predict();
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        if (k == 0 && n == 18) run = 1'b0;
        mem_stall = !(ismem && k >= 4 + s);
        mem_rdata = (ismem && k == 4 + s) ? rdv[memop]
                                          : 32'hDEADBEEF;
        if (k == 0) begin
          chk("retired", {16'h0, retired}, mret);
          chk("illegal", {31'h0, illegal}, {31'h0, mill});
          chk("fetch_pc", {22'h0, inst_addr}, {22'h0, mpc});
          lit(n);
        end
        dbg_sel = sel;
        sel     = sel + 5'd1;
        #1;
        inwin = ismem && k >= 3 && k <= lat - 2;
        chk("state", {29'h0, state},
            {29'h0, phase(k, lat, ismem)});
        chk("mem_rd", {31'h0, mem_rd}, {31'h0, inwin && islw});
        chk("mem_wr", {31'h0, mem_wr}, {31'h0, inwin && issw});
        chk("mem_addr", {20'h0, mem_addr},
            inwin ? {20'h0, addr[11:0]} : 32'h0);
        chk("mem_wdata", mem_wdata,
            (inwin && issw) ? wdat : 32'h0);
        chk("dbg_reg", dbg_reg, mregs[dbg_sel]);
        if (k == lat - 1)
          chk("next_pc", {22'h0, inst_addr}, {22'h0, nxt});
        if (mem_wr && mem_addr == 12'd4 && mem_wdata == 32'd5)
          wcnt++;
        total++;
      end
      if (wr && wa != 5'd0) mregs[wa] = wv;
      mpc  = nxt;
      mret = mret + 1;
      if (ill) mill = 1'b1;
      if (ismem) memop++;
    end

    @(negedge clk); #1;
    chk("halt_state", {29'h0, state}, {29'h0, S_HALT});
    chk("halt_retired", {16'h0, retired}, 32'd19);
    repeat (2) @(negedge clk);
    #1;
    chk("halt_hold", {29'h0, state}, {29'h0, S_HALT});
    chk("halt_pc", {22'h0, inst_addr}, 32'd16);
    for (int r = 0; r < 32; r++) begin
      dbg_sel = 5'(r); #1;
      chk("final_reg", dbg_reg, mregs[r]);
    end

    // reset while a load is stuck in MEM_WAIT
    rom[16]   = 32'h8C0C0000; // lw $12,0($0)
    mem_stall = 1'b1;
    @(negedge clk) run = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #1;
      if (state == S_MEM_WAIT) found = 1'b1;
    end
    chk("reach_mem_wait", {31'h0, found}, 32'd1);
    if (found) begin
      chk("wait_rd", {31'h0, mem_rd}, 32'd1);
      rst_n = 1'b0; #1;
      chk("arst_rd", {31'h0, mem_rd}, 32'd0);
      chk("arst_state", {29'h0, state}, {29'h0, S_HALT});
      chk("arst_pc", {22'h0, inst_addr}, 32'd0);
      chk("arst_retired", {16'h0, retired}, 32'd0);
      chk("arst_illegal", {31'h0, illegal}, 32'd0);
      dbg_sel = 5'd1; #1;
      chk("arst_r1", dbg_reg, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
